pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit_pkg.sv | 20 ++
 rtl/pc_fetch_unit_redirect_buf.sv | 38 +++
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_pkg : shared state encoding and default vectors for pc_fetch_unit     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT       = 2'd0,
      RUN        = 2'd1,
      WAIT       = 2'd2,
      WAIT_REDIR = 2'd3
   } pc_state_t;

   localparam int unsigned c_XLEN         = 32;
   localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] c_TRAP_VECTOR  = 32'h0000_0100;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_redirect_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_redirect_buf : one-entry pending redirect target (load overwrites)    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = c_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] target,
   output logic            pend_valid,
   output logic [XLEN-1:0] pend_target
);

   logic            r_valid;
   logic [XLEN-1:0] r_target;

   // Clear wins over load so a trap in the same cycle discards the new target.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_valid  <= 1'b0;
         r_target <= '0;
      end else if (load) begin
         r_valid  <= 1'b1;
         r_target <= target;
      end
   end

   assign pend_valid  = r_valid;
   assign pend_target = r_target;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_unit : program counter with valid/ready fetch and redirect buf  |
// | Optional macro PC_MISALIGN_TRAP_EN traps misaligned redirects. Rev 1.0   |
// +--------------------------------------------------------------------------+
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int unsigned      XLEN         = c_XLEN,
   parameter logic [XLEN-1:0]  RESET_VECTOR = c_RESET_VECTOR,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = c_TRAP_VECTOR,
   parameter int unsigned      INSTR_BYTES  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_next_seq,
   output logic            misalign_fault
);

   localparam logic [XLEN-1:0] c_INCR       = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

   pc_state_t       r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt, w_pc_seq;
   logic            r_misalign, w_misalign_nxt;
   logic            w_fetch_valid, w_fire;
   logic            w_buf_load, w_buf_clear, w_pend_valid;
   logic [XLEN-1:0] w_pend_target, w_tgt;
   logic            w_tgt_bad;

`ifdef PC_MISALIGN_TRAP_EN
   assign w_tgt     = redirect_target;
   assign w_tgt_bad = |(redirect_target & c_ALIGN_MASK);
`else
   assign w_tgt     = redirect_target & ~c_ALIGN_MASK;
   assign w_tgt_bad = 1'b0;
`endif

   assign w_pc_seq = r_pc + c_INCR;
   assign w_fire   = w_fetch_valid && fetch_ready;

   always_comb begin
      case (r_state)
         BOOT:    w_fetch_valid = 1'b0;
         RUN:     w_fetch_valid = !stall;
         default: w_fetch_valid = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_misalign_nxt = 1'b0;
      w_buf_load     = 1'b0;
      w_buf_clear    = 1'b0;
      if (trap_valid) begin
         w_state_nxt = RUN;
         w_pc_nxt    = TRAP_VECTOR;
         w_buf_clear = 1'b1;
      end else if (redirect_valid && w_tgt_bad && (r_state != BOOT)) begin
         // A misaligned redirect behaves like a trap and is flagged.
         w_state_nxt    = RUN;
         w_pc_nxt       = TRAP_VECTOR;
         w_buf_clear    = 1'b1;
         w_misalign_nxt = 1'b1;
      end else begin
         case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
               if (redirect_valid)     w_pc_nxt    = w_tgt;
               else if (w_fire)        w_pc_nxt    = w_pc_seq;
               else if (w_fetch_valid) w_state_nxt = WAIT;
            end
            WAIT, WAIT_REDIR: begin
               if (w_fire) begin
                  w_state_nxt = RUN;
                  w_buf_clear = 1'b1;
                  if (redirect_valid)    w_pc_nxt = w_tgt;
                  else if (w_pend_valid) w_pc_nxt = w_pend_target;
                  else                   w_pc_nxt = w_pc_seq;
               end else if (redirect_valid) begin
                  w_buf_load  = 1'b1;
                  w_state_nxt = WAIT_REDIR;
               end
            end
            default: w_state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_misalign <= w_misalign_nxt;
      end
   end

   pc_redirect_buf #(
      .XLEN (XLEN)
   ) u_redirect_buf (
      .clk         (clk),
      .reset       (reset),
      .load        (w_buf_load),
      .clear       (w_buf_clear),
      .target      (w_tgt),
      .pend_valid  (w_pend_valid),
      .pend_target (w_pend_target)
   );

   assign fetch_valid    = w_fetch_valid;
   assign pc_out         = r_pc;
   assign pc_next_seq    = w_pc_seq;
   assign misalign_fault = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed scoreboard bench for pc_fetch_unit           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_unit;

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [31:0] c_MIS_PC  = 32'h0000_0100;
   localparam logic        c_MIS_FLT = 1'b1;
`else
   localparam logic [31:0] c_MIS_PC  = 32'h0000_0040;
   localparam logic        c_MIS_FLT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        trap_valid = 1'b0;
   logic        fetch_ready = 1'b0;
   logic        fetch_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_next_seq;
   logic        misalign_fault;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        fv;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   pc_fetch_unit u_dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .fetch_ready     (fetch_ready),
      .fetch_valid     (fetch_valid),
      .pc_out          (pc_out),
      .pc_next_seq     (pc_next_seq),
      .misalign_fault  (misalign_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Apply one cycle of inputs, queue the outputs expected after the edge, then compare.
   task automatic step(input string tag, input logic rst, input logic st, input logic rdy,
                       input logic rv, input logic [31:0] rt, input logic tv,
                       input logic [31:0] epc, input logic efv, input logic emis);
      exp_t e;
      reset           = rst;
      stall           = st;
      fetch_ready     = rdy;
      redirect_valid  = rv;
      redirect_target = rt;
      trap_valid      = tv;
      e.tag = tag; e.pc = epc; e.fv = efv; e.mis = emis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, ".pc"},   pc_out,         e.pc);
         check({e.tag, ".fv"},   {31'd0, fetch_valid},    {31'd0, e.fv});
         check({e.tag, ".mis"},  {31'd0, misalign_fault}, {31'd0, e.mis});
         check({e.tag, ".seq"},  pc_next_seq,    e.pc + 32'd4);
      end
   endtask

   initial begin
      //     tag           rst st rdy rv target        tv  exp_pc               fv mis
      step("rst",          1, 0, 1, 0, 32'h0,        0, 32'h0,               0, 0);
      step("boot",         0, 0, 1, 0, 32'h0,        0, 32'h0,               1, 0);
      step("seq4",         0, 0, 1, 0, 32'h0,        0, 32'h4,               1, 0);
      step("seq8",         0, 0, 1, 0, 32'h0,        0, 32'h8,               1, 0);
      step("wait1",        0, 0, 0, 0, 32'h0,        0, 32'h8,               1, 0);
      step("wait2",        0, 0, 0, 0, 32'h0,        0, 32'h8,               1, 0);
      step("wait_stall",   0, 1, 0, 0, 32'h0,        0, 32'h8,               1, 0);
      step("hs_c",         0, 0, 1, 0, 32'h0,        0, 32'hC,               1, 0);
      step("seq10",        0, 0, 1, 0, 32'h0,        0, 32'h10,              1, 0);
      step("wait10",       0, 0, 0, 0, 32'h0,        0, 32'h10,              1, 0);
      step("pend40",       0, 0, 0, 1, 32'h40,       0, 32'h10,              1, 0);
      step("pend80",       0, 0, 0, 1, 32'h80,       0, 32'h10,              1, 0);
      step("hs_pend",      0, 0, 1, 0, 32'h0,        0, 32'h80,              1, 0);
      step("seq84",        0, 0, 1, 0, 32'h0,        0, 32'h84,              1, 0);
      step("wait84",       0, 0, 0, 0, 32'h0,        0, 32'h84,              1, 0);
      step("pend200",      0, 0, 0, 1, 32'h200,      0, 32'h84,              1, 0);
      step("trap",         0, 0, 0, 1, 32'h300,      1, 32'h100,             1, 0);
      step("trap_seq",     0, 0, 1, 0, 32'h0,        0, 32'h104,             1, 0);
      step("wait104",      0, 0, 0, 0, 32'h0,        0, 32'h104,             1, 0);
      step("hs108",        0, 0, 1, 0, 32'h0,        0, 32'h108,             1, 0);
      step("wait108",      0, 0, 0, 0, 32'h0,        0, 32'h108,             1, 0);
      step("pend500",      0, 0, 0, 1, 32'h500,      0, 32'h108,             1, 0);
      step("hs_new",       0, 0, 1, 1, 32'h600,      0, 32'h600,             1, 0);
      step("mis42",        0, 0, 1, 1, 32'h42,       0, c_MIS_PC,            1, c_MIS_FLT);
      step("mis_after",    0, 0, 1, 0, 32'h0,        0, c_MIS_PC + 32'h4,    1, 0);
      step("stall",        0, 1, 1, 0, 32'h0,        0, c_MIS_PC + 32'h4,    0, 0);
      step("unstall",      0, 0, 1, 0, 32'h0,        0, c_MIS_PC + 32'h8,    1, 0);
      step("redir_ffc",    0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC,      1, 0);
      step("wrap",         0, 0, 1, 0, 32'h0,        0, 32'h0,               1, 0);
      step("redir20",      0, 0, 1, 1, 32'h20,       0, 32'h20,              1, 0);
      step("wait20",       0, 0, 0, 0, 32'h0,        0, 32'h20,              1, 0);
      step("rst_mid",      1, 0, 0, 1, 32'h30,       1, 32'h0,               0, 0);
      step("reboot",       0, 0, 1, 0, 32'h0,        0, 32'h0,               1, 0);
      step("reboot_seq",   0, 0, 1, 0, 32'h0,        0, 32'h4,               1, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
